// File: rtl/alu_n_pkg.sv
// Shared constants for the parametrised multi-cycle ALU: opcodes, flag-register
// bit positions, shift-mode encodings and the controller state type.
package alu_n_pkg;

  localparam logic [5:0] OP_ADD    = 6'b100000;
  localparam logic [5:0] OP_SUB    = 6'b100001;
  localparam logic [5:0] OP_MUL    = 6'b100010;
  localparam logic [5:0] OP_DIV    = 6'b100011;
  localparam logic [5:0] OP_INCDEC = 6'b100100;
  localparam logic [5:0] OP_MOD    = 6'b100101;
  localparam logic [5:0] OP_CMP    = 6'b010110;
  localparam logic [5:0] OP_AND    = 6'b010010;
  localparam logic [5:0] OP_OR     = 6'b010011;
  localparam logic [5:0] OP_XOR    = 6'b010100;
  localparam logic [5:0] OP_NOT    = 6'b010101;
  localparam logic [5:0] OP_SHIFT  = 6'b010000;
  localparam logic [5:0] OP_FRPASS = 6'b000110;

  localparam int FR_GT    = 15;
  localparam int FR_LT    = 14;
  localparam int FR_EQ    = 13;
  localparam int FR_ZERO  = 12;
  localparam int FR_CARRY = 11;
  localparam int FR_OVF   = 10;
  localparam int FR_DIVZ  = 9;
  localparam int FR_NEG   = 6;

  localparam logic [2:0] SH_SHL_ZERO = 3'b000;
  localparam logic [2:0] SH_SHL_ONES = 3'b001;
  localparam logic [2:0] SH_SHR_ZERO = 3'b010;
  localparam logic [2:0] SH_SHR_ONES = 3'b011;
  // Rotates are selected by the upper two mode bits; bit 0 is a don't-care.
  localparam logic [1:0] SH_ROT_LEFT  = 2'b10;
  localparam logic [1:0] SH_ROT_RIGHT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_MUL,
    ST_DIVIDE
  } alu_state_e;

  function automatic logic is_div_op(input logic [5:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_serial_divider.sv
// Unsigned restoring divider producing one quotient bit per clock, MSB first.
// Divide-by-zero is never loaded here; the parent resolves it directly.
module alu_serial_divider #(
  parameter int WIDTH = 16
) (
  input  logic             wire_clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             valid
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_div;
  logic [CNT_W-1:0] r_count;
  logic             r_valid;

  logic [WIDTH:0]   w_shifted;
  logic [WIDTH:0]   w_trial;
  logic             w_fits;

  // Partial remainder stays below the divisor, so WIDTH+1 bits hold the trial.
  always_comb begin
    w_shifted = {r_rem, r_quo[WIDTH-1]};
    w_trial   = w_shifted - {1'b0, r_div};
    w_fits    = ~w_trial[WIDTH];
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge wire_clock) begin
    if (reset) begin
      r_count <= '0;
      r_valid <= 1'b0;
    end else if (load) begin
      r_count <= CNT_W'(WIDTH);
      r_valid <= 1'b0;
    end else if (r_count != '0) begin
      r_count <= r_count - CNT_W'(1);
      r_valid <= (r_count == CNT_W'(1));
    end
  end

  // NOTE: datapath registers carry no reset; they are only consumed once r_valid qualifies them.
  always_ff @(posedge wire_clock) begin
    if (load) begin
      r_quo <= dividend;
      r_rem <= '0;
      r_div <= divisor;
    end else if (r_count != '0) begin
      r_quo <= {r_quo[WIDTH-2:0], w_fits};
      r_rem <= w_fits ? w_trial[WIDTH-1:0] : w_shifted[WIDTH-1:0];
    end
  end

  assign quotient  = r_quo;
  assign remainder = r_rem;
  assign valid     = r_valid;

endmodule

// File: rtl/alu_multicycle_n.sv
// Handshaked multi-cycle ALU: captures a request on start, computes in one,
// two or WIDTH+1 edges, then pulses done with registered result and flags.
module alu_multicycle_n
  import alu_n_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FR_W  = 16
) (
  input  logic             wire_clock,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       op_code,
  input  logic             use_carry,
  input  logic             dec,
  input  logic [2:0]       shift_mode,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [FR_W-1:0]  fr_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [FR_W-1:0]  fr_out
);

  localparam int               SH_W     = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] LP_ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] LP_ONES  = '1;
  localparam logic [WIDTH-1:0] LP_WIDTH = WIDTH'(WIDTH);

  alu_state_e         r_state;
  alu_state_e         w_state_next;
  logic               r_busy, w_busy_next;
  logic               r_done, w_done_next;
  logic [WIDTH-1:0]   r_result, w_result_next;
  logic [FR_W-1:0]    r_fr_out, w_fr_next;

  logic [5:0]         r_op;
  logic               r_use_carry;
  logic               r_dec;
  logic [2:0]         r_mode;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [FR_W-1:0]    r_fr;
  logic [2*WIDTH-1:0] r_prod;

  logic               w_accept;
  logic               w_div_load;
  logic [WIDTH-1:0]   w_quotient;
  logic [WIDTH-1:0]   w_remainder;
  logic               w_div_valid;

  logic               w_cin;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic               w_big_shift;
  logic [SH_W-1:0]    w_rot_amt;
  logic [WIDTH-1:0]   w_rotl;
  logic [WIDTH-1:0]   w_rotr;
  logic [WIDTH-1:0]   w_shift_res;

  assign w_accept   = (r_state == ST_IDLE) && start;
  assign w_div_load = w_accept && is_div_op(op_code) && (operand_b != '0);

  alu_serial_divider #(.WIDTH(WIDTH)) u_divider (
    .wire_clock (wire_clock),
    .reset      (reset),
    .load       (w_div_load),
    .dividend   (operand_a),
    .divisor    (operand_b),
    .quotient   (w_quotient),
    .remainder  (w_remainder),
    .valid      (w_div_valid)
  );

  always_ff @(posedge wire_clock) begin
    if (w_accept) begin
      r_op        <= op_code;
      r_use_carry <= use_carry;
      r_dec       <= dec;
      r_mode      <= shift_mode;
      r_a         <= operand_a;
      r_b         <= operand_b;
      r_fr        <= fr_in;
    end
    if (r_state == ST_EXEC) begin
      r_prod <= {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};
    end
  end

  // Shared arithmetic on the captured operands; the FSM picks what it needs.
  always_comb begin
    w_cin       = r_use_carry & r_fr[FR_CARRY];
    w_sum       = {1'b0, r_a} + {1'b0, r_b} + {{WIDTH{1'b0}}, w_cin};
    w_diff      = {1'b0, r_a} - {1'b0, r_b} - {{WIDTH{1'b0}}, w_cin};
    w_big_shift = (r_b >= LP_WIDTH);
    w_rot_amt   = r_b[SH_W-1:0];
    w_rotl      = (r_a << w_rot_amt) | (r_a >> (WIDTH - int'(w_rot_amt)));
    w_rotr      = (r_a >> w_rot_amt) | (r_a << (WIDTH - int'(w_rot_amt)));
    w_shift_res = '0;
    if (r_mode[2:1] == SH_ROT_LEFT) begin
      w_shift_res = w_rotl;
    end else if (r_mode[2:1] == SH_ROT_RIGHT) begin
      w_shift_res = w_rotr;
    end else begin
      case (r_mode)
        SH_SHL_ZERO: w_shift_res = w_big_shift ? '0 : (r_a << r_b);
        SH_SHL_ONES: w_shift_res = w_big_shift ? '1 : ((r_a << r_b) | ~(LP_ONES << r_b));
        SH_SHR_ZERO: w_shift_res = w_big_shift ? '0 : (r_a >> r_b);
        SH_SHR_ONES: w_shift_res = w_big_shift ? '1 : ((r_a >> r_b) | ~(LP_ONES >> r_b));
        default:     w_shift_res = '0;
      endcase
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next  = r_state;
    w_busy_next   = r_busy;
    w_done_next   = 1'b0;
    w_result_next = r_result;
    w_fr_next     = r_fr_out;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_next = ST_EXEC;
      end
      ST_EXEC: begin
        w_state_next = ST_IDLE;
        w_done_next  = 1'b1;
        w_fr_next    = r_fr;
        case (r_op)
          OP_ADD: begin
            w_result_next       = w_sum[WIDTH-1:0];
            w_fr_next[FR_CARRY] = w_sum[WIDTH];
            w_fr_next[FR_ZERO]  = ~|w_result_next;
          end
          OP_SUB: begin
            w_result_next      = w_diff[WIDTH-1:0];
            w_fr_next[FR_NEG]  = w_diff[WIDTH];
            w_fr_next[FR_ZERO] = ~|w_result_next;
          end
          OP_MUL: begin
            w_state_next = ST_MUL;
            w_done_next  = 1'b0;
            w_busy_next  = 1'b1;
          end
          OP_DIV, OP_MOD: begin
            if (r_b == '0) begin
              w_result_next      = '0;
              w_fr_next[FR_DIVZ] = 1'b1;
              w_fr_next[FR_ZERO] = 1'b1;
            end else begin
              w_state_next = ST_DIVIDE;
              w_done_next  = 1'b0;
              w_busy_next  = 1'b1;
            end
          end
          OP_INCDEC: begin
            w_result_next       = r_dec ? (r_a - LP_ONE) : (r_a + LP_ONE);
            w_fr_next[FR_CARRY] = r_dec ? (r_a == '0) : (r_a == LP_ONES);
            w_fr_next[FR_ZERO]  = ~|w_result_next;
          end
          OP_CMP: begin
            w_fr_next[FR_GT] = (r_a > r_b);
            w_fr_next[FR_LT] = (r_a < r_b);
            w_fr_next[FR_EQ] = (r_a == r_b);
          end
          OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHIFT: begin
            case (r_op)
              OP_AND:  w_result_next = r_a & r_b;
              OP_OR:   w_result_next = r_a | r_b;
              OP_XOR:  w_result_next = r_a ^ r_b;
              OP_NOT:  w_result_next = ~r_a;
              default: w_result_next = w_shift_res;
            endcase
            w_fr_next[FR_ZERO] = ~|w_result_next;
          end
          OP_FRPASS: ;
          default: begin
            w_fr_next = r_fr_out;
          end
        endcase
      end
      ST_MUL: begin
        w_state_next       = ST_IDLE;
        w_busy_next        = 1'b0;
        w_done_next        = 1'b1;
        w_result_next      = r_prod[WIDTH-1:0];
        w_fr_next          = r_fr;
        w_fr_next[FR_OVF]  = |r_prod[2*WIDTH-1:WIDTH];
        w_fr_next[FR_ZERO] = ~|w_result_next;
      end
      ST_DIVIDE: begin
        if (w_div_valid) begin
          w_state_next       = ST_IDLE;
          w_busy_next        = 1'b0;
          w_done_next        = 1'b1;
          w_result_next      = (r_op == OP_MOD) ? w_remainder : w_quotient;
          w_fr_next          = r_fr;
          w_fr_next[FR_DIVZ] = 1'b0;
          w_fr_next[FR_ZERO] = ~|w_result_next;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge wire_clock) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_fr_out <= '0;
    end else begin
      r_state  <= w_state_next;
      r_busy   <= w_busy_next;
      r_done   <= w_done_next;
      r_result <= w_result_next;
      r_fr_out <= w_fr_next;
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign fr_out = r_fr_out;

endmodule

// File: tb/tb_alu_multicycle_n.sv
// Self-checking bench for alu_multicycle_n (WIDTH=16): directed cases, random
// operations against a bit-level reference model, and reset-abort scenarios.
module tb_alu_multicycle_n;

  localparam int W   = 16;
  localparam int FRW = 16;

  localparam logic [5:0] T_ADD = 6'b100000, T_SUB = 6'b100001, T_MUL = 6'b100010;
  localparam logic [5:0] T_DIV = 6'b100011, T_INC = 6'b100100, T_MOD = 6'b100101;
  localparam logic [5:0] T_CMP = 6'b010110, T_AND = 6'b010010, T_OR  = 6'b010011;
  localparam logic [5:0] T_XOR = 6'b010100, T_NOT = 6'b010101, T_SHF = 6'b010000;
  localparam logic [5:0] T_FRP = 6'b000110;

  logic           clk = 1'b0;
  logic           reset, start, use_carry, dec;
  logic [5:0]     op_code;
  logic [2:0]     shift_mode;
  logic [W-1:0]   operand_a, operand_b, result;
  logic [FRW-1:0] fr_in, fr_out;
  logic           busy, done;

  int total = 0;
  int bad   = 0;
  logic [W-1:0]   m_result = '0;
  logic [FRW-1:0] m_fr     = '0;

  always #5 clk = ~clk;

  alu_multicycle_n #(.WIDTH(W), .FR_W(FRW)) dut (
    .wire_clock (clk),
    .reset      (reset),
    .start      (start),
    .op_code    (op_code),
    .use_carry  (use_carry),
    .dec        (dec),
    .shift_mode (shift_mode),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .fr_in      (fr_in),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .fr_out     (fr_out)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: integer arithmetic and per-bit shift/rotate loops.
  function automatic void model(input logic [5:0] op, input logic uc, input logic dc,
                                input logic [2:0] md, input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] fr, output logic [15:0] r,
                                output logic [15:0] f, output int lat);
    int ia, ib, cin, s, k, src;
    longint p;
    logic [15:0] t;
    r = m_result; f = fr; lat = 1;
    ia = int'(a); ib = int'(b);
    cin = (uc && fr[11]) ? 1 : 0;
    case (op)
      T_ADD: begin s = ia + ib + cin; r = 16'(s % 65536); f[11] = (s >= 65536); f[12] = (r == 0); end
      T_SUB: begin s = ia - ib - cin; r = 16'((s + 65536) % 65536); f[6] = (s < 0); f[12] = (r == 0); end
      T_MUL: begin
        p = longint'(ia) * longint'(ib); lat = 2;
        r = 16'(p % 65536); f[10] = (p >= 65536); f[12] = (r == 0);
      end
      T_DIV, T_MOD: begin
        if (ib == 0) begin r = 16'h0; f[9] = 1'b1; f[12] = 1'b1; end
        else begin
          r = 16'((op == T_DIV) ? (ia / ib) : (ia % ib)); f[9] = 1'b0; f[12] = (r == 0); lat = 17;
        end
      end
      T_INC: begin
        if (dc) begin r = 16'((ia + 65535) % 65536); f[11] = (ia == 0); end
        else    begin r = 16'((ia + 1) % 65536);     f[11] = (ia == 65535); end
        f[12] = (r == 0);
      end
      T_CMP: begin f[15] = (ia > ib); f[14] = (ia < ib); f[13] = (ia == ib); end
      T_AND: begin r = a & b; f[12] = (r == 0); end
      T_OR:  begin r = a | b; f[12] = (r == 0); end
      T_XOR: begin r = a ^ b; f[12] = (r == 0); end
      T_NOT: begin r = ~a;    f[12] = (r == 0); end
      T_SHF: begin
        k = ib % 16;
        for (int i = 0; i < 16; i++) begin
          if (md[2]) begin
            t[i] = md[1] ? a[(i + k) % 16] : a[(i - k + 16) % 16];
          end else begin
            src  = md[1] ? (i + ib) : (i - ib);
            t[i] = (src >= 0 && src < 16) ? a[src] : md[0];
          end
        end
        r = t; f[12] = (r == 0);
      end
      T_FRP: ;
      default: f = m_fr;
    endcase
  endfunction

  task automatic issue(input logic [5:0] op, input logic uc, input logic dc, input logic [2:0] md,
                       input logic [15:0] a, input logic [15:0] b, input logic [15:0] fr,
                       input bit inject, input string name);
    logic [15:0] er, ef;
    int el, lat, busy_cnt, overlap, extra;
    bit got;
    model(op, uc, dc, md, a, b, fr, er, ef, el);
    op_code = op; use_carry = uc; dec = dc; shift_mode = md;
    operand_a = a; operand_b = b; fr_in = fr; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op_code = 6'($urandom); operand_a = 16'($urandom); operand_b = 16'($urandom);
    fr_in = 16'($urandom); use_carry = 1'($urandom); dec = 1'($urandom); shift_mode = 3'($urandom);
    lat = 0; got = 0; busy_cnt = 0; overlap = 0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      start = (inject && lat == 3);
      if (busy) busy_cnt++;
      if (busy && done) overlap++;
      if (done) got = 1;
    end
    start = 1'b0;
    check({name, "_latency"}, 64'(lat), 64'(el));
    check({name, "_result"}, result, er);
    check({name, "_fr"}, fr_out, ef);
    check({name, "_busy_cycles"}, 64'(busy_cnt), 64'(el - 1));
    check({name, "_busy_done_overlap"}, 64'(overlap), 64'd0);
    @(negedge clk);
    extra = int'(done);
    if (inject) repeat (4) begin @(negedge clk); extra += int'(done); end
    check({name, "_done_pulse"}, 64'(extra), 64'd0);
    m_result = er;
    m_fr     = ef;
  endtask

  function automatic logic [15:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'h0001;
      2: return 16'hFFFF;
      3: return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic reset_mid_div(input bit issue_after);
    int dones;
    issue(T_ADD, 1'b0, 1'b0, 3'b000, 16'h0001, 16'h0001, 16'hFFFF, 1'b0, "pre_reset_add");
    op_code = T_DIV; operand_a = 16'd100; operand_b = 16'd7; fr_in = 16'h0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_done", done, 1'b0);
    check("rst_mid_result", result, 16'h0000);
    check("rst_mid_fr", fr_out, 16'h0000);
    m_result = '0;
    m_fr     = '0;
    reset = 1'b0;
    if (issue_after) begin
      issue(T_ADD, 1'b0, 1'b0, 3'b000, 16'h1234, 16'h0101, 16'h0000, 1'b0, "post_reset_add");
    end else begin
      dones = 0;
      repeat (24) begin @(negedge clk); dones += int'(done); end
      check("rst_abort_no_done", 64'(dones), 64'd0);
    end
  endtask

  logic [5:0] ops [16] = '{T_ADD, T_SUB, T_MUL, T_DIV, T_MOD, T_INC, T_CMP, T_AND,
                           T_OR, T_XOR, T_NOT, T_SHF, T_FRP, 6'b000000, 6'b111111, 6'b100110};

  initial begin
    logic [5:0]  op;
    logic [15:0] a, b;
    reset = 1'b1; start = 1'b0; op_code = '0; use_carry = 1'b0; dec = 1'b0;
    shift_mode = '0; operand_a = '0; operand_b = '0; fr_in = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_result", result, 16'h0000);
    check("reset_fr", fr_out, 16'h0000);
    reset = 1'b0;
    @(negedge clk);

    issue(T_ADD, 1'b0, 1'b0, 3'b000, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, "add_wrap");
    issue(T_SUB, 1'b1, 1'b0, 3'b000, 16'h0003, 16'h0005, 16'h0A05, 1'b0, "sub_borrow");
    issue(T_MUL, 1'b0, 1'b0, 3'b000, 16'h0100, 16'h0100, 16'h0000, 1'b0, "mul_ovf");
    issue(T_MUL, 1'b0, 1'b0, 3'b000, 16'h0003, 16'h0005, 16'h0000, 1'b0, "mul_small");
    issue(T_DIV, 1'b0, 1'b0, 3'b000, 16'd100,  16'd7,    16'h0000, 1'b1, "div_100_7");
    issue(T_MOD, 1'b0, 1'b0, 3'b000, 16'd100,  16'd7,    16'h0000, 1'b0, "mod_100_7");
    issue(T_DIV, 1'b0, 1'b0, 3'b000, 16'd5,    16'd0,    16'h0000, 1'b0, "div_by_zero");
    issue(T_SHF, 1'b0, 1'b0, 3'b100, 16'h8001, 16'd1,    16'h0000, 1'b0, "rotl_1");
    issue(T_SHF, 1'b0, 1'b0, 3'b001, 16'h0001, 16'd4,    16'h0000, 1'b0, "shl_ones_4");
    issue(T_SHF, 1'b0, 1'b0, 3'b010, 16'hBEEF, 16'd20,   16'h0000, 1'b0, "shr_big");
    issue(T_SHF, 1'b0, 1'b0, 3'b110, 16'h0001, 16'd17,   16'h0000, 1'b0, "rotr_17");
    issue(T_INC, 1'b0, 1'b1, 3'b000, 16'h0000, 16'h0000, 16'h0000, 1'b0, "dec_wrap");
    issue(T_CMP, 1'b0, 1'b0, 3'b000, 16'h0010, 16'h0010, 16'h1FFF, 1'b0, "cmp_equal");
    issue(6'b111111, 1'b0, 1'b0, 3'b000, 16'h5555, 16'h1111, 16'hFFFF, 1'b0, "unknown_op");

    for (int n = 0; n < 200; n++) begin
      op = ops[$urandom_range(0, 15)];
      a  = pick_val();
      b  = (op == T_SHF && $urandom_range(0, 3) != 0) ? 16'($urandom_range(0, 20)) : pick_val();
      issue(op, 1'($urandom), 1'($urandom), 3'($urandom), a, b, 16'($urandom), 1'b0, "rand");
    end

    reset_mid_div(1'b1);
    reset_mid_div(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
